// File: rtl/wishbone_interconnect_1xn_pkg.sv
// wishbone_interconnect_1xn_pkg: shared bus FSM encodings, default memory map and slave indices
package wishbone_interconnect_1xn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_ERR_RESP = 2'd2
    } bus_state_t;

    localparam int SLV_ROM    = 0;
    localparam int SLV_RAM    = 1;
    localparam int SLV_PERIPH = 2;
    localparam int SLV_ACCEL  = 3;

    localparam logic [127:0] DEF_SLAVE_BASE = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [127:0] DEF_SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};

endpackage

// File: rtl/wishbone_interconnect_1xn_decoder.sv
// wb_addr_decoder: address -> per-slave hit vector and lowest-index winning slave
module wb_addr_decoder
    import wishbone_interconnect_1xn_pkg::*;
#(
    parameter int                         NUM_SLAVES = 4,
    parameter int                         IW         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK = DEF_SLAVE_MASK
) (
    input  logic [31:0]            i_addr,
    output logic [NUM_SLAVES-1:0]  o_hit,
    output logic [IW-1:0]          o_idx
);

    // Scanning downward lets the lowest hit overwrite any higher one on overlap.
    always_comb begin
        o_hit = '0;
        o_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            o_hit[i] = (i_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32];
            if (o_hit[i]) o_idx = IW'(i);
        end
    end

endmodule

// File: rtl/wishbone_interconnect_1xn.sv
// wishbone_interconnect_1xn: single-master Wishbone classic router to NUM_SLAVES with decode-miss
// and timeout watchdog that answers with err and records the faulting address.
module wishbone_interconnect_1xn
    import wishbone_interconnect_1xn_pkg::*;
#(
    parameter int                         NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_BASE     = DEF_SLAVE_BASE,
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK     = DEF_SLAVE_MASK,
    parameter int                         TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  m_wb_addr,
    input  logic [31:0]                  m_wb_dat_i,
    output logic [31:0]                  m_wb_dat_o,
    input  logic                         m_wb_we,
    input  logic [3:0]                   m_wb_sel,
    input  logic                         m_wb_stb,
    input  logic                         m_wb_cyc,
    output logic                         m_wb_ack,
    output logic                         m_wb_err,
    output logic [31:0]                  s_wb_addr,
    output logic [31:0]                  s_wb_dat_o,
    output logic                         s_wb_we,
    output logic [3:0]                   s_wb_sel,
    output logic [NUM_SLAVES-1:0]        s_wb_stb,
    output logic [NUM_SLAVES-1:0]        s_wb_cyc,
    input  logic [32*NUM_SLAVES-1:0]     s_wb_dat_i,
    input  logic [NUM_SLAVES-1:0]        s_wb_ack,
    input  logic [NUM_SLAVES-1:0]        s_wb_err,
    output logic                         bus_err_valid,
    output logic [31:0]                  bus_err_addr
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    bus_state_t             r_state;
    logic [IW-1:0]          r_sel;
    logic [TW-1:0]          r_timer;
    logic [31:0]            r_err_addr;

    logic [NUM_SLAVES-1:0]  w_hit;
    logic [IW-1:0]          w_idx;
    logic                   w_req;
    logic                   w_fwd;
    logic                   w_sel_ack;
    logic                   w_sel_err;

    wb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .IW         (IW),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .i_addr (m_wb_addr),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    assign w_req     = m_wb_cyc & m_wb_stb;
    // Gating on the live request makes an abort drop the slave lines in the same cycle.
    assign w_fwd     = (r_state == ST_ACTIVE) & w_req;
    assign w_sel_ack = s_wb_ack[r_sel];
    assign w_sel_err = s_wb_err[r_sel];

    assign s_wb_addr  = m_wb_addr;
    assign s_wb_dat_o = m_wb_dat_i;
    assign s_wb_we    = m_wb_we;
    assign s_wb_sel   = m_wb_sel;
    assign s_wb_stb   = w_fwd ? (NUM_SLAVES'(1) << r_sel) : '0;
    assign s_wb_cyc   = w_fwd ? (NUM_SLAVES'(1) << r_sel) : '0;

    assign m_wb_dat_o    = (r_state == ST_ACTIVE) ? s_wb_dat_i[r_sel*32 +: 32] : 32'h0;
    assign m_wb_ack      = w_fwd & w_sel_ack & ~w_sel_err;
    assign m_wb_err      = (w_fwd & w_sel_err) | (r_state == ST_ERR_RESP);
    assign bus_err_valid = r_state == ST_ERR_RESP;
    assign bus_err_addr  = r_err_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_timer    <= '0;
            r_err_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && |w_hit) begin
                        r_state <= ST_ACTIVE;
                        r_sel   <= w_idx;
                        r_timer <= '0;
                    end else if (w_req) begin
                        r_state    <= ST_ERR_RESP;
                        r_err_addr <= m_wb_addr;
                    end
                end
                ST_ACTIVE: begin
                    if (!w_req || w_sel_ack || w_sel_err) begin
                        r_state <= ST_IDLE;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state    <= ST_ERR_RESP;
                        r_err_addr <= m_wb_addr;
                    end else begin
                        r_timer <= (r_timer == '1) ? r_timer : r_timer + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_interconnect_1xn.sv
// tb_wishbone_interconnect_1xn: directed self-checking bench for the 1xN Wishbone interconnect
module tb_wishbone_interconnect_1xn;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  m_wb_addr, m_wb_dat_i, m_wb_dat_o;
    logic         m_wb_we, m_wb_stb, m_wb_cyc, m_wb_ack, m_wb_err;
    logic [3:0]   m_wb_sel;
    logic [31:0]  s_wb_addr, s_wb_dat_o;
    logic         s_wb_we;
    logic [3:0]   s_wb_sel, s_wb_stb, s_wb_cyc, s_wb_ack, s_wb_err;
    logic [127:0] s_wb_dat_i;
    logic         bus_err_valid;
    logic [31:0]  bus_err_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;
    int k;

    always #5 clk = ~clk;

    wishbone_interconnect_1xn dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_wb_addr     (m_wb_addr),
        .m_wb_dat_i    (m_wb_dat_i),
        .m_wb_dat_o    (m_wb_dat_o),
        .m_wb_we       (m_wb_we),
        .m_wb_sel      (m_wb_sel),
        .m_wb_stb      (m_wb_stb),
        .m_wb_cyc      (m_wb_cyc),
        .m_wb_ack      (m_wb_ack),
        .m_wb_err      (m_wb_err),
        .s_wb_addr     (s_wb_addr),
        .s_wb_dat_o    (s_wb_dat_o),
        .s_wb_we       (s_wb_we),
        .s_wb_sel      (s_wb_sel),
        .s_wb_stb      (s_wb_stb),
        .s_wb_cyc      (s_wb_cyc),
        .s_wb_dat_i    (s_wb_dat_i),
        .s_wb_ack      (s_wb_ack),
        .s_wb_err      (s_wb_err),
        .bus_err_valid (bus_err_valid),
        .bus_err_addr  (bus_err_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] a, input logic we);
        m_wb_addr = a;
        m_wb_we   = we;
        m_wb_cyc  = 1'b1;
        m_wb_stb  = 1'b1;
    endtask

    task automatic idle();
        m_wb_cyc = 1'b0;
        m_wb_stb = 1'b0;
        s_wb_ack = 4'b0;
        s_wb_err = 4'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        m_wb_addr  = 32'h0;
        m_wb_dat_i = 32'h1234_5678;
        m_wb_we    = 1'b0;
        m_wb_sel   = 4'hF;
        s_wb_dat_i = '0;
        idle();
        step(); step(); #1;
        check("rst_stb", 32'(s_wb_stb), 32'h0);
        check("rst_ack_err", {30'b0, m_wb_ack, m_wb_err}, 32'h0);
        check("rst_dat_o", m_wb_dat_o, 32'h0);
        check("rst_err_valid_addr", {31'b0, bus_err_valid} | bus_err_addr, 32'h0);
        rst_n = 1'b1;

        // Read from slave 1 with a two-cycle slave latency
        step(); req(32'h1000_0004, 1'b0); #1;
        check("t1_decode_cycle_stb", 32'(s_wb_stb), 32'h0);
        step(); #1;
        check("t1_stb", 32'(s_wb_stb), 32'h2);
        check("t1_cyc", 32'(s_wb_cyc), 32'h2);
        check("t1_bcast_addr", s_wb_addr, 32'h1000_0004);
        check("t1_bcast_dat", s_wb_dat_o, 32'h1234_5678);
        check("t1_no_ack_yet", 32'(m_wb_ack), 32'h0);
        step();
        s_wb_ack = 4'b0010;
        s_wb_dat_i[32 +: 32] = 32'hDEAD_BEEF;
        #1;
        check("t1_ack", {30'b0, m_wb_ack, m_wb_err}, 32'h2);
        check("t1_dat_o", m_wb_dat_o, 32'hDEAD_BEEF);
        step();
        m_wb_cyc = 1'b0;
        m_wb_stb = 1'b0;
        #1;
        check("t1_stray_ack_ignored", 32'(m_wb_ack), 32'h0);
        check("t1_dat_o_idle", m_wb_dat_o, 32'h0);
        s_wb_ack = 4'b0;

        // Unmapped write
        step(); req(32'h3000_0000, 1'b1); #1;
        check("t2_req_cycle_err", 32'(m_wb_err), 32'h0);
        step(); #1;
        check("t2_err", {30'b0, m_wb_err, bus_err_valid}, 32'h3);
        check("t2_no_stb", 32'(s_wb_stb | s_wb_cyc), 32'h0);
        check("t2_err_addr", bus_err_addr, 32'h3000_0000);
        idle();
        step(); #1;
        check("t2_err_one_cycle", {30'b0, m_wb_err, bus_err_valid}, 32'h0);
        check("t2_err_addr_hold", bus_err_addr, 32'h3000_0000);

        // Slave 2 never answers
        step(); req(32'h2000_0010, 1'b0);
        cnt = 0;
        for (k = 0; k < 300; k++) begin
            step(); #1;
            if (m_wb_err) break;
            if (s_wb_stb == 4'b0100 && s_wb_cyc == 4'b0100) cnt++;
        end
        check("t3_err_seen", 32'(k < 300), 32'h1);
        check("t3_active_cycles", 32'(cnt), 32'd255);
        check("t3_slave_dropped", 32'(s_wb_stb | s_wb_cyc), 32'h0);
        check("t3_err_valid", 32'(bus_err_valid), 32'h1);
        check("t3_err_addr", bus_err_addr, 32'h2000_0010);
        idle();
        step(); #1;
        check("t3_err_cleared", {30'b0, m_wb_err, bus_err_valid}, 32'h0);

        // Slave 0 raises ack and err together; a foreign ack comes first
        step(); req(32'h0000_0100, 1'b0);
        step();
        s_wb_ack = 4'b0010;
        #1;
        check("t4_stb", 32'(s_wb_stb), 32'h1);
        check("t4_foreign_ack_ignored", {30'b0, m_wb_ack, m_wb_err}, 32'h0);
        step();
        s_wb_ack = 4'b0001;
        s_wb_err = 4'b0001;
        #1;
        check("t4_err_wins", {30'b0, m_wb_ack, m_wb_err}, 32'h1);
        check("t4_no_bus_err_valid", 32'(bus_err_valid), 32'h0);
        step(); idle();

        // Master aborts slave 3 transfer
        s_wb_dat_i[96 +: 32] = 32'hCAFE_0003;
        step(); req(32'h4000_0008, 1'b0);
        step(); #1;
        check("t5_stb", 32'(s_wb_stb), 32'h8);
        step();
        m_wb_cyc = 1'b0;
        #1;
        check("t5_abort_drop", 32'(s_wb_stb | s_wb_cyc), 32'h0);
        check("t5_abort_no_resp", {30'b0, m_wb_ack, m_wb_err}, 32'h0);
        step(); idle(); #1;
        check("t5_idle_dat_o", m_wb_dat_o, 32'h0);

        // Async reset during an active transfer
        step(); req(32'h1000_0000, 1'b0);
        step();
        s_wb_ack = 4'b0010;
        #1;
        check("t6_pre_reset_ack", 32'(m_wb_ack), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_reset_stb", 32'(s_wb_stb | s_wb_cyc), 32'h0);
        check("t6_reset_ack_err", {30'b0, m_wb_ack, m_wb_err}, 32'h0);
        check("t6_reset_err_addr", bus_err_addr, 32'h0);
        check("t6_reset_dat_o", m_wb_dat_o, 32'h0);
        step();
        rst_n = 1'b1;
        s_wb_ack = 4'b0;
        step(); #1;
        check("t6_after_release_stb", 32'(s_wb_stb), 32'h2);
        s_wb_ack = 4'b0010;
        #1;
        check("t6_after_release_ack", 32'(m_wb_ack), 32'h1);
        check("t6_after_release_dat", m_wb_dat_o, 32'hDEAD_BEEF);
        step(); idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
